adc_serial_deser_align: RTL

- Parametrised successor to the AD9276 8-channel capture path: deserialises NCH serial ADC lanes of BITS-bit words and aligns word boundaries against the frame (FCO) lane by bitslip.
- Reports lock/loss, presents aligned parallel words with a valid strobe, and gates FIFO writes.
- Sits after the LVDS input buffers and bit-clock recovery, which deliver one bit per lane per clk; output feeds the sample FIFO.

---
 rtl/adc_serial_deser_align.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/adc_serial_deser_align.sv
// ---------------------------------------------------------------------------
// adc_serial_deser_align
//
// Deserialises NCH serial ADC data lanes of BITS-bit words and finds the word
// boundary by bit-slipping against the frame (FCO) lane. Once the frame lane
// has matched LOCK_COUNT times in a row the block is locked and presents the
// aligned parallel words with a one-cycle valid strobe and a gated FIFO write.
//
// Ports
//   clk        : bit clock, one bit per lane sampled on each rising edge
//   _rst       : asynchronous active-low reset (release expected synchronous
//                to clk from the upstream reset controller)
//   _wen       : active-low FIFO write enable, only gates fifo_we
//   fco        : serial frame lane
//   din        : serial data lanes, bit i is lane i
//   dout       : aligned words, lane i at [i*BITS +: BITS]
//   dout_valid : one-cycle pulse when dout carries new words
//   fifo_we    : dout_valid qualified by _wen, registered on the same edge
//   locked     : high while in the LOCKED state
//   align_err  : sticky, set after 2*BITS search slips without a match
//   slip_cnt   : saturating number of slips since reset
// ---------------------------------------------------------------------------
module adc_serial_deser_align #(
    parameter int NCH        = 8,
    parameter int BITS       = 14,
    parameter int MSB_FIRST  = 1,
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 2
) (
    input  logic                clk,
    input  logic                _rst,
    input  logic                _wen,
    input  logic                fco,
    input  logic [NCH-1:0]      din,
    output logic [NCH*BITS-1:0] dout,
    output logic                dout_valid,
    output logic                fifo_we,
    output logic                locked,
    output logic                align_err,
    output logic [7:0]          slip_cnt
);

    localparam int CW = $clog2(BITS);
    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int LW = $clog2(LOSS_COUNT + 1);
    localparam int SW = $clog2(2 * BITS + 1);

    localparam logic [CW-1:0] CNT_LAST   = CW'(BITS - 1);
    localparam logic [MW-1:0] LOCK_LAST  = MW'(LOCK_COUNT - 1);
    localparam logic [LW-1:0] LOSS_LAST  = LW'(LOSS_COUNT - 1);
    localparam logic [SW-1:0] SLIP_LAST  = SW'(2 * BITS - 1);
    // Frame word in arrival order: earliest bit in the MSB.
    localparam logic [BITS-1:0] FRAME_PAT = {{(BITS/2){1'b1}}, {(BITS/2){1'b0}}};

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // Reverse bit order so the first received bit lands in bit 0.
    function automatic logic [BITS-1:0] bit_reverse(input logic [BITS-1:0] v);
        logic [BITS-1:0] r;
        for (int k = 0; k < BITS; k++) begin
            r[k] = v[BITS-1-k];
        end
        return r;
    endfunction

    logic [BITS-2:0]     lane_sr_r [NCH];
    logic [BITS-2:0]     fco_sr_r;
    logic [CW-1:0]       bit_cnt_r;
    logic                slip_hold_r;
    state_t              state_r, state_nx;
    logic [MW-1:0]       match_cnt_r, match_cnt_nx;
    logic [LW-1:0]       miss_cnt_r, miss_cnt_nx;
    logic [SW-1:0]       search_slips_r, search_slips_nx;
    logic [NCH*BITS-1:0] dout_r;
    logic                dout_valid_r;
    logic                fifo_we_r;
    logic                locked_r;
    logic                align_err_r;
    logic [7:0]          slip_cnt_r;

    logic                boundary_s;
    logic                frame_match_s;
    logic                slip_req_s;
    logic                load_s;
    logic                err_set_s;
    logic [BITS-1:0]     fco_word_s;
    logic [NCH*BITS-1:0] cand_s;

    // The held extra edge after a slip is deliberately not a boundary.
    assign boundary_s    = (bit_cnt_r == CNT_LAST) && !slip_hold_r;
    assign frame_match_s = (fco_word_s == FRAME_PAT);

    // Candidate words: previous BITS-1 shifted bits plus the bit on this edge.
    always_comb begin
        fco_word_s = {fco_sr_r, fco};
        cand_s     = {(NCH*BITS){1'b0}};
        for (int i = 0; i < NCH; i++) begin
            if (MSB_FIRST != 0) begin
                cand_s[i*BITS +: BITS] = {lane_sr_r[i], din[i]};
            end else begin
                cand_s[i*BITS +: BITS] = bit_reverse({lane_sr_r[i], din[i]});
            end
        end
    end

    // Serial shift registers; they keep shifting through slip cycles.
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            fco_sr_r <= {(BITS-1){1'b0}};
            for (int i = 0; i < NCH; i++) begin
                lane_sr_r[i] <= {(BITS-1){1'b0}};
            end
        end else begin
            fco_sr_r <= {fco_sr_r[BITS-3:0], fco};
            for (int i = 0; i < NCH; i++) begin
                lane_sr_r[i] <= {lane_sr_r[i][BITS-3:0], din[i]};
            end
        end
    end

    // Bit counter; a slip holds it at BITS-1 for one extra edge.
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            bit_cnt_r   <= {CW{1'b0}};
            slip_hold_r <= 1'b0;
        end else if (slip_hold_r) begin
            bit_cnt_r   <= {CW{1'b0}};
            slip_hold_r <= 1'b0;
        end else if (bit_cnt_r == CNT_LAST) begin
            if (slip_req_s) begin
                bit_cnt_r   <= bit_cnt_r;
                slip_hold_r <= 1'b1;
            end else begin
                bit_cnt_r   <= {CW{1'b0}};
                slip_hold_r <= 1'b0;
            end
        end else begin
            bit_cnt_r   <= bit_cnt_r + CW'(1);
            slip_hold_r <= 1'b0;
        end
    end

    // Alignment FSM next state; only boundary edges can change anything.
    always_comb begin
        state_nx        = state_r;
        match_cnt_nx    = match_cnt_r;
        miss_cnt_nx     = miss_cnt_r;
        search_slips_nx = search_slips_r;
        slip_req_s      = 1'b0;
        load_s          = 1'b0;
        err_set_s       = 1'b0;
        if (boundary_s) begin
            case (state_r)
                ST_SEARCH: begin
                    if (frame_match_s) begin
                        if (LOCK_COUNT == 1) begin
                            state_nx        = ST_LOCKED;
                            match_cnt_nx    = {MW{1'b0}};
                            search_slips_nx = {SW{1'b0}};
                        end else begin
                            state_nx     = ST_CHECK;
                            match_cnt_nx = MW'(1);
                        end
                    end else begin
                        slip_req_s = 1'b1;
                        if (search_slips_r == SLIP_LAST) begin
                            search_slips_nx = {SW{1'b0}};
                            err_set_s       = 1'b1;
                        end else begin
                            search_slips_nx = search_slips_r + SW'(1);
                        end
                    end
                end
                ST_CHECK: begin
                    if (frame_match_s) begin
                        if (match_cnt_r == LOCK_LAST) begin
                            state_nx        = ST_LOCKED;
                            match_cnt_nx    = {MW{1'b0}};
                            search_slips_nx = {SW{1'b0}};
                        end else begin
                            match_cnt_nx = match_cnt_r + MW'(1);
                        end
                    end else begin
                        slip_req_s   = 1'b1;
                        match_cnt_nx = {MW{1'b0}};
                        state_nx     = ST_SEARCH;
                    end
                end
                ST_LOCKED: begin
                    if (frame_match_s) begin
                        load_s      = 1'b1;
                        miss_cnt_nx = {LW{1'b0}};
                    end else if (miss_cnt_r == LOSS_LAST) begin
                        // Boundary is kept: a loss is usually a glitch, not a shift.
                        state_nx    = ST_SEARCH;
                        miss_cnt_nx = {LW{1'b0}};
                    end else begin
                        miss_cnt_nx = miss_cnt_r + LW'(1);
                    end
                end
                default: begin
                    state_nx     = ST_SEARCH;
                    match_cnt_nx = {MW{1'b0}};
                    miss_cnt_nx  = {LW{1'b0}};
                end
            endcase
        end else begin
            state_nx = state_r;
        end
    end

    // Alignment FSM state and counters.
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            state_r        <= ST_SEARCH;
            match_cnt_r    <= {MW{1'b0}};
            miss_cnt_r     <= {LW{1'b0}};
            search_slips_r <= {SW{1'b0}};
        end else begin
            state_r        <= state_nx;
            match_cnt_r    <= match_cnt_nx;
            miss_cnt_r     <= miss_cnt_nx;
            search_slips_r <= search_slips_nx;
        end
    end

    // Registered outputs and status flags.
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            dout_r       <= {(NCH*BITS){1'b0}};
            dout_valid_r <= 1'b0;
            fifo_we_r    <= 1'b0;
            locked_r     <= 1'b0;
            align_err_r  <= 1'b0;
            slip_cnt_r   <= 8'd0;
        end else begin
            if (load_s) begin
                dout_r <= cand_s;
            end else begin
                dout_r <= dout_r;
            end
            dout_valid_r <= load_s;
            fifo_we_r    <= load_s & ~_wen;
            locked_r     <= (state_nx == ST_LOCKED);
            align_err_r  <= align_err_r | err_set_s;
            if (slip_req_s && (slip_cnt_r != 8'hFF)) begin
                slip_cnt_r <= slip_cnt_r + 8'd1;
            end else begin
                slip_cnt_r <= slip_cnt_r;
            end
        end
    end

    assign dout       = dout_r;
    assign dout_valid = dout_valid_r;
    assign fifo_we    = fifo_we_r;
    assign locked     = locked_r;
    assign align_err  = align_err_r;
    assign slip_cnt   = slip_cnt_r;

endmodule
